// File: rtl/branch_resolve_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// branch_resolve_ctrl_pkg
// Purpose : Shared constants and helpers for the stage-3 branch resolve block.
//           It holds the RV32 opcode codes (inst[6:2]), the branch func3 codes,
//           the pc_sel encodings returned to fetch and a branch-direction
//           helper.
// Ports   : none (package)
// ----------------------------------------------------------------------------
package branch_resolve_ctrl_pkg;

  // Major opcodes, inst[6:2]
  localparam logic [4:0] OPC_BRANCH_5 = 5'b11000;
  localparam logic [4:0] OPC_JALR_5   = 5'b11001;
  localparam logic [4:0] OPC_JAL_5    = 5'b11011;

  // Branch func3, inst[14:12]
  localparam logic [2:0] FNC_BEQ  = 3'b000;
  localparam logic [2:0] FNC_BNE  = 3'b001;
  localparam logic [2:0] FNC_BLT  = 3'b100;
  localparam logic [2:0] FNC_BGE  = 3'b101;
  localparam logic [2:0] FNC_BLTU = 3'b110;
  localparam logic [2:0] FNC_BGEU = 3'b111;

  // pc_sel encodings returned to fetch
  localparam logic [1:0] PC_SEL_NEXT    = 2'd0;
  localparam logic [1:0] PC_SEL_TARGET  = 2'd1;
  localparam logic [1:0] PC_SEL_RECOVER = 2'd2;
  localparam logic [1:0] PC_SEL_RESET   = 2'd3;

  typedef struct packed {
    logic legal;   // func3 names a real branch
    logic actual;  // resolved direction (0 when not legal)
  } br_dir_t;

  // Resolve the direction of a conditional branch from the comparator flags.
  // Signedness is applied upstream, so BLT/BLTU share brlt and BGE/BGEU
  // share !brlt.
  function automatic br_dir_t resolve_dir(input logic [2:0] func3,
                                          input logic       breq,
                                          input logic       brlt);
    br_dir_t d;
    d.legal  = 1'b1;
    d.actual = 1'b0;
    case (func3)
      FNC_BEQ:            d.actual = breq;
      FNC_BNE:            d.actual = ~breq;
      FNC_BLT, FNC_BLTU:  d.actual = brlt;
      FNC_BGE, FNC_BGEU:  d.actual = ~brlt;
      default:            d.legal  = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/branch_resolve_ctrl_sat_ctr_table.sv
// ----------------------------------------------------------------------------
// sat_ctr_table
// Purpose : Table of saturating direction counters. It has one combinational
//           read port and one write port that moves one entry up or down by
//           one per cycle and stops at 0 and at all-ones.
// Ports   : i_clk, i_rst_n (async, active low)
//           i_rd_idx / o_rd_ctr     : combinational read (returns the old value)
//           i_wr_en, i_wr_idx, i_wr_inc : write port (inc=1 up, inc=0 down)
// ----------------------------------------------------------------------------
module sat_ctr_table #(
  parameter int ENTRIES  = 32,
  parameter int CTR_BITS = 2,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [IDX_W-1:0]    i_rd_idx,
  output logic [CTR_BITS-1:0] o_rd_ctr,
  input  logic                i_wr_en,
  input  logic [IDX_W-1:0]    i_wr_idx,
  input  logic                i_wr_inc
);

  // Weakly not-taken: MSB clear, all lower bits set.
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

  logic [CTR_BITS-1:0] r_ctr [ENTRIES];
  logic [CTR_BITS-1:0] w_old;
  logic [CTR_BITS-1:0] w_new;

  // No write-to-read bypass: a same-index read sees the pre-update value.
  assign o_rd_ctr = r_ctr[i_rd_idx];
  assign w_old    = r_ctr[i_wr_idx];

  always_comb begin
    w_new = w_old;
    if (i_wr_inc) begin
      if (w_old != CTR_MAX) w_new = w_old + CTR_BITS'(1);
    end else begin
      if (w_old != '0) w_new = w_old - CTR_BITS'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= CTR_INIT;
    end else if (i_wr_en) begin
      r_ctr[i_wr_idx] <= w_new;
    end
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// ----------------------------------------------------------------------------
// branch_resolve_ctrl
// Purpose : Stage-3 branch/jump resolution. It drives pc_sel/flush to fetch,
//           trains a PC-indexed direction-counter table that fetch reads for
//           predictions, ignores stage-3 valids for a short shadow after each
//           redirect, and counts resolved branches and mispredicts.
// Ports   : i_clk, i_rst_n (async, active low)
//           i_pred_pc -> o_pred_taken       : fetch-side prediction read
//           i_res_valid, i_res_inst, i_res_pc, i_res_pred_taken,
//           i_breq, i_brlt                  : stage-3 resolution inputs
//           i_stats_clr                     : synchronous clear of the stats
//           o_pc_sel, o_flush               : redirect to fetch
//           o_br_count, o_mispred_count     : statistics
// ----------------------------------------------------------------------------
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int ENTRIES      = 32,
  parameter int CTR_BITS     = 2,
  parameter int FLUSH_SHADOW = 2,
  parameter int STAT_W       = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [31:0]       i_pred_pc,
  output logic              o_pred_taken,
  input  logic              i_res_valid,
  input  logic [31:0]       i_res_inst,
  input  logic [31:0]       i_res_pc,
  input  logic              i_res_pred_taken,
  input  logic              i_breq,
  input  logic              i_brlt,
  input  logic              i_stats_clr,
  output logic [1:0]        o_pc_sel,
  output logic              o_flush,
  output logic [STAT_W-1:0] o_br_count,
  output logic [STAT_W-1:0] o_mispred_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int SH_W  = (FLUSH_SHADOW < 1) ? 1 : $clog2(FLUSH_SHADOW + 1);

  logic [SH_W-1:0]     r_shadow;
  logic [STAT_W-1:0]   r_br_count;
  logic [STAT_W-1:0]   r_mispred_count;

  logic                w_eff_v;
  logic [4:0]          w_opc;
  br_dir_t             w_dir;
  logic                w_is_br;
  logic [1:0]          w_pc_sel;
  logic                w_flush;
  logic                w_upd;
  logic [CTR_BITS-1:0] w_pred_ctr;
  logic                w_unused;

  assign w_eff_v = i_res_valid & (r_shadow == '0);
  assign w_opc   = i_res_inst[6:2];
  assign w_dir   = resolve_dir(i_res_inst[14:12], i_breq, i_brlt);
  assign w_is_br = (w_opc == OPC_BRANCH_5) & w_dir.legal;

  always_comb begin
    w_pc_sel = PC_SEL_NEXT;
    if (w_eff_v) begin
      if (w_opc == OPC_JAL_5 || w_opc == OPC_JALR_5) begin
        w_pc_sel = PC_SEL_TARGET;
      end else if (w_is_br) begin
        if (w_dir.actual && !i_res_pred_taken)      w_pc_sel = PC_SEL_TARGET;
        else if (!w_dir.actual && i_res_pred_taken) w_pc_sel = PC_SEL_RECOVER;
      end
    end
  end

  // Reset forces the reset vector combinationally, independent of the inputs.
  assign w_flush  = (w_pc_sel == PC_SEL_TARGET) | (w_pc_sel == PC_SEL_RECOVER);
  assign o_flush  = w_flush & i_rst_n;
  assign o_pc_sel = i_rst_n ? w_pc_sel : PC_SEL_RESET;

  // Only legal, effective branches train the table; jumps never do.
  assign w_upd = w_eff_v & w_is_br;

  sat_ctr_table #(
    .ENTRIES  (ENTRIES),
    .CTR_BITS (CTR_BITS)
  ) u_table (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_rd_idx (i_pred_pc[IDX_W+1:2]),
    .o_rd_ctr (w_pred_ctr),
    .i_wr_en  (w_upd),
    .i_wr_idx (i_res_pc[IDX_W+1:2]),
    .i_wr_inc (w_dir.actual)
  );

  assign o_pred_taken = w_pred_ctr[CTR_BITS-1];

  // The shadow cannot be re-triggered while nonzero because eff_v is low then.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shadow <= '0;
    end else if (o_flush) begin
      r_shadow <= SH_W'(FLUSH_SHADOW);
    end else if (r_shadow != '0) begin
      r_shadow <= r_shadow - SH_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_br_count      <= '0;
      r_mispred_count <= '0;
    end else if (i_stats_clr) begin
      r_br_count      <= '0;
      r_mispred_count <= '0;
    end else if (w_upd) begin
      r_br_count <= r_br_count + STAT_W'(1);
      if (w_flush) r_mispred_count <= r_mispred_count + STAT_W'(1);
    end
  end

  assign o_br_count      = r_br_count;
  assign o_mispred_count = r_mispred_count;

  // Instruction and PC bits this block never looks at.
  assign w_unused = ^{i_res_inst[31:15], i_res_inst[11:7], i_res_inst[1:0],
                      i_pred_pc[31:IDX_W+2], i_pred_pc[1:0],
                      i_res_pc[31:IDX_W+2], i_res_pc[1:0]};

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
module tb_branch_resolve_ctrl;

  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   pred_pc;
  logic          pred_taken;
  logic          res_valid;
  logic [31:0]   res_inst;
  logic [31:0]   res_pc;
  logic          res_pred_taken;
  logic          breq;
  logic          brlt;
  logic          stats_clr;
  logic [1:0]    pc_sel;
  logic          flush;
  logic [SW-1:0] br_count;
  logic [SW-1:0] mispred_count;

  int checks   = 0;
  int failures = 0;
  int m_br     = 0;
  int m_mis    = 0;

  always #5 clk = ~clk;

  branch_resolve_ctrl #(
    .ENTRIES(32), .CTR_BITS(2), .FLUSH_SHADOW(2), .STAT_W(SW)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_pred_pc        (pred_pc),
    .o_pred_taken     (pred_taken),
    .i_res_valid      (res_valid),
    .i_res_inst       (res_inst),
    .i_res_pc         (res_pc),
    .i_res_pred_taken (res_pred_taken),
    .i_breq           (breq),
    .i_brlt           (brlt),
    .i_stats_clr      (stats_clr),
    .o_pc_sel         (pc_sel),
    .o_flush          (flush),
    .o_br_count       (br_count),
    .o_mispred_count  (mispred_count)
  );

  localparam logic [31:0] JAL  = 32'h0000_006F;
  localparam logic [31:0] JALR = 32'h0000_0067;
  localparam logic [31:0] ADDI = 32'h0000_0013;

  function automatic logic [31:0] mk_br(input logic [2:0] f3);
    return {17'b0, f3, 5'b0, 7'b1100011};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic pt, input logic eq, input logic lt);
    res_valid = v; res_inst = inst; res_pc = pc;
    res_pred_taken = pt; breq = eq; brlt = lt;
  endtask

  task automatic idle();
    res_valid = 1'b0; res_inst = ADDI; res_pred_taken = 1'b0;
    breq = 1'b0; brlt = 1'b0; stats_clr = 1'b0;
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_br_count"}, 32'(br_count), 32'(m_br % 16));
    check({tag, "_mispred_count"}, 32'(mispred_count), 32'(m_mis % 16));
  endtask

  typedef struct {
    logic        valid;
    logic [31:0] inst;
    logic        pt;
    logic        eq;
    logic        lt;
    logic [1:0]  sel;
    logic        fl;
    logic        is_br;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{1'b1, mk_br(3'b000), 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1}; // BEQ taken, predicted
    vecs[1]  = '{1'b1, mk_br(3'b000), 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1}; // BEQ not taken, mispredicted
    vecs[2]  = '{1'b1, mk_br(3'b001), 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1}; // BNE taken, missed
    vecs[3]  = '{1'b1, mk_br(3'b100), 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1}; // BLT taken, predicted
    vecs[4]  = '{1'b1, mk_br(3'b101), 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1}; // BGE not taken
    vecs[5]  = '{1'b1, mk_br(3'b110), 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1}; // BLTU not taken
    vecs[6]  = '{1'b1, mk_br(3'b111), 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1}; // BGEU taken, missed
    vecs[7]  = '{1'b1, JAL,           1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0}; // JAL
    vecs[8]  = '{1'b1, JALR,          1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0}; // JALR
    vecs[9]  = '{1'b1, ADDI,          1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0}; // non-branch
    vecs[10] = '{1'b1, mk_br(3'b011), 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0}; // illegal func3
    vecs[11] = '{1'b0, mk_br(3'b000), 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0}; // bubble
    vecs[12] = '{1'b1, mk_br(3'b001), 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1}; // BNE not taken, predicted

    // ---------------- reset state ----------------
    rst_n = 1'b0; pred_pc = 32'h0C; res_pc = 32'h0; idle();
    #2;
    check("rst_pc_sel", 32'(pc_sel), 32'd3);
    check("rst_flush", 32'(flush), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("init_pred_taken", 32'(pred_taken), 32'd0);
    check_stats("init");

    // ---------------- decode table ----------------
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].valid, vecs[i].inst, 32'h50 + 32'(i) * 4, vecs[i].pt, vecs[i].eq, vecs[i].lt);
      #1;
      check($sformatf("vec%0d_pc_sel", i), 32'(pc_sel), 32'(vecs[i].sel));
      check($sformatf("vec%0d_flush", i), 32'(flush), 32'(vecs[i].fl));
      $display("vec %0d inst=%08h pc_sel=%0d flush=%0d", i, res_inst, pc_sel, flush);
      tick();
      idle();
      if (vecs[i].is_br) begin
        m_br++;
        if (vecs[i].sel != 2'd0) m_mis++;
      end
      check_stats($sformatf("vec%0d", i));
      tick(); tick();
    end

    // ---------------- BEQ at 0x40, missed taken ----------------
    stats_clr = 1'b1; tick(); stats_clr = 1'b0; m_br = 0; m_mis = 0;
    pred_pc = 32'h40;
    drive(1'b1, mk_br(3'b000), 32'h40, 1'b0, 1'b1, 1'b0);
    #1;
    check("beq_pc_sel", 32'(pc_sel), 32'd1);
    check("beq_flush", 32'(flush), 32'd1);
    check("beq_pred_before", 32'(pred_taken), 32'd0);
    tick(); idle();
    m_br++; m_mis++;
    check("beq_pred_after", 32'(pred_taken), 32'd1);
    check_stats("beq");
    $display("seq beq40 pc_sel=1 pred_taken=%0d br=%0d mis=%0d", pred_taken, br_count, mispred_count);
    tick(); tick();

    // ---------------- BNE recover then shadow ----------------
    drive(1'b1, mk_br(3'b001), 32'h44, 1'b1, 1'b1, 1'b0);
    #1;
    check("bne_pc_sel", 32'(pc_sel), 32'd2);
    check("bne_flush", 32'(flush), 32'd1);
    tick();
    m_br++; m_mis++;
    drive(1'b1, JAL, 32'h48, 1'b0, 1'b0, 1'b0);
    #1;
    check("shadow1_pc_sel", 32'(pc_sel), 32'd0);
    check("shadow1_flush", 32'(flush), 32'd0);
    tick();
    check("shadow2_pc_sel", 32'(pc_sel), 32'd0);
    tick();
    check("shadow_end_pc_sel", 32'(pc_sel), 32'd1);
    check("shadow_end_flush", 32'(flush), 32'd1);
    $display("seq shadow jal pc_sel=%0d", pc_sel);
    tick(); idle();
    check_stats("shadow");
    tick(); tick();

    // ---------------- saturation at pc 0x20 ----------------
    pred_pc = 32'h20;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, mk_br(3'b100), 32'h20, 1'b1, 1'b0, 1'b1);
      #1;
      check($sformatf("sat%0d_pc_sel", i), 32'(pc_sel), 32'd0);
      tick();
      m_br++;
    end
    idle();
    check("sat_pred_taken", 32'(pred_taken), 32'd1);
    drive(1'b1, mk_br(3'b100), 32'h20, 1'b1, 1'b0, 1'b0);
    #1;
    check("sat_nt1_pc_sel", 32'(pc_sel), 32'd2);
    tick(); idle(); m_br++; m_mis++;
    check("sat_nt1_pred_taken", 32'(pred_taken), 32'd1);
    tick(); tick();
    drive(1'b1, mk_br(3'b100), 32'h20, 1'b1, 1'b0, 1'b0);
    #1;
    tick(); idle(); m_br++; m_mis++;
    check("sat_nt2_pred_taken", 32'(pred_taken), 32'd0);
    check_stats("sat");
    $display("seq saturation pred_taken=%0d br=%0d mis=%0d", pred_taken, br_count, mispred_count);
    tick(); tick();

    // ---------------- same-index read/update at idx 5 ----------------
    pred_pc = 32'h14;
    drive(1'b1, mk_br(3'b000), 32'h14, 1'b1, 1'b1, 1'b0);
    #1;
    check("rw_pc_sel", 32'(pc_sel), 32'd0);
    check("rw_pred_same_cycle", 32'(pred_taken), 32'd0);
    tick(); idle(); m_br++;
    check("rw_pred_next_cycle", 32'(pred_taken), 32'd1);
    drive(1'b1, mk_br(3'b010), 32'h14, 1'b1, 1'b0, 1'b0);
    #1;
    check("illegal_pc_sel", 32'(pc_sel), 32'd0);
    check("illegal_flush", 32'(flush), 32'd0);
    tick(); idle();
    check("illegal_no_update", 32'(pred_taken), 32'd1);
    check_stats("illegal");
    $display("seq idx5 pred_taken=%0d br=%0d", pred_taken, br_count);

    // ---------------- stats wrap and clear priority ----------------
    stats_clr = 1'b1; tick(); stats_clr = 1'b0; m_br = 0; m_mis = 0;
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, mk_br(3'b000), 32'h60, 1'b0, 1'b0, 1'b0);
      tick();
    end
    idle();
    check("wrap15_br_count", 32'(br_count), 32'd15);
    drive(1'b1, mk_br(3'b000), 32'h60, 1'b0, 1'b0, 1'b0);
    tick(); idle();
    check("wrap16_br_count", 32'(br_count), 32'd0);
    check("wrap16_mispred_count", 32'(mispred_count), 32'd0);
    drive(1'b1, mk_br(3'b000), 32'h64, 1'b0, 1'b1, 1'b0);
    tick(); idle();
    check("pre_clr_br_count", 32'(br_count), 32'd1);
    check("pre_clr_mispred_count", 32'(mispred_count), 32'd1);
    tick(); tick();
    drive(1'b1, mk_br(3'b000), 32'h64, 1'b0, 1'b1, 1'b0);
    stats_clr = 1'b1;
    tick(); idle();
    m_br = 0; m_mis = 0;
    check_stats("clr_prio");
    $display("seq stats br=%0d mis=%0d", br_count, mispred_count);
    tick(); tick();

    // ---------------- reset mid-run ----------------
    pred_pc = 32'h0C;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, mk_br(3'b000), 32'h0C, 1'b1, 1'b1, 1'b0);
      tick();
      m_br++;
    end
    idle();
    check("train3_pred_taken", 32'(pred_taken), 32'd1);
    drive(1'b1, mk_br(3'b000), 32'h0C, 1'b0, 1'b1, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_pc_sel", 32'(pc_sel), 32'd3);
    check("midrst_flush", 32'(flush), 32'd0);
    tick(); idle();
    rst_n = 1'b1;
    m_br = 0; m_mis = 0;
    tick();
    check("postrst_pred_taken", 32'(pred_taken), 32'd0);
    check("postrst_pc_sel", 32'(pc_sel), 32'd0);
    check_stats("postrst");
    $display("seq reset pred_taken=%0d br=%0d mis=%0d", pred_taken, br_count, mispred_count);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
